serial_addsub_ctrl: RTL
=======================

Name: serial_addsub_ctrl

Overview:
Bit-serial adder/subtractor controller. It sequences a single 1-bit full-adder cell over WIDTH clock cycles to add or subtract two WIDTH-bit operands, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/done handshake. It sits between a register-file/ALU front end and the shared full-adder cell, and trades area for latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset; clears all state immediately
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high in RUN
done  output  1  one-cycle pulse when result is final
result  output  WIDTH  sum/difference; held stable from done until next accepted start
cout  output  1  final carry out (sub: 1 = no borrow)
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; shift regs, carry FF and counter all 0. Assertion mid-operation aborts immediately. No partial result is retained.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> load opA=a, opB = sub ? ~b : b, carry=sub, cnt=0 -> RUN. start=0 -> stay.
- RUN: busy=1. Each cycle:
  - FA inputs are opA[0], opB[0] and carry.
  - sum is shifted into the result shift register at the MSB, shifting right.
  - opA and opB shift right; carry <= FA carry; cnt++.
  - On the cycle where cnt==WIDTH-2, capture the FA carry into the MSB as c_msb.
  - When cnt==WIDTH-1 (last bit processed): cout <= FA carry; ovf <= c_msb ^ FA carry; -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE. start is ignored in DONE.
- Latency: start sampled at edge 0 -> busy from edge 0 for WIDTH cycles -> done high in the cycle after edge WIDTH. The next start is accepted at the earliest in the cycle after done.
- start or operand changes while busy or in DONE are ignored. Operands are captured only at acceptance.
- result/cout/ovf update only when leaving RUN. They hold their values through IDLE.
- Wrap-around: sums are modulo 2^WIDTH. cout reports the wrap.

Optional Feature:
Macro SERIAL_ADDSUB_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in RUN -> IDLE next edge with no done pulse; result/cout/ovf keep their previous values. abort in IDLE/DONE has no effect. If start and abort are both high in IDLE, start wins.
- Undefined: no abort port. RUN always completes.

Decomposition:
- Package serial_addsub_pkg holds:
  - the state typedef/localparams (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2)
  - the default WIDTH constant
- One sub-module: fa_cell (a, b, cin -> sum, cout), purely combinational, instantiated once.
- Counter, shift registers and FSM stay in serial_addsub_ctrl.

Test Plan:
- WIDTH=8, a=0x3C, b=0x05, sub=0, start 1 cycle -> busy for 8 cycles, done pulse, result=0x41, cout=0, ovf=0.
- a=0x7F, b=0x01, sub=0 -> result=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0.
- a=0x05, b=0x07, sub=1 -> result=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
- Start 0x10+0x20; at RUN cycle 3, pulse start with a=0xFF, b=0xFF -> ignored; result=0x30 and exactly one done pulse.
- Start 0x3C+0x05; drop rst_n at RUN cycle 4 -> busy/done/result/cout/ovf go 0 immediately, no done pulse. After release, a fresh 0x01+0x01 gives 0x02.
- With SERIAL_ADDSUB_ABORT_EN: complete 0x11+0x22 (result=0x33), then start 0x01+0x01 and abort at RUN cycle 2 -> no done pulse, result stays 0x33, IDLE next cycle.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and constants for the bit-serial add/sub
// controller.
//   state_t     - controller FSM state encoding (IDLE/RUN/DONE)
//   DEF_WIDTH   - default operand/result width
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder shared by the serial controller.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial adder/subtractor controller. Sequences a
// single fa_cell over WIDTH cycles, LSB first.
// Optional feature: define SERIAL_ADDSUB_ABORT_EN to add the abort input.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   start, sub     - request and op select (0 add, 1 subtract), sampled in IDLE
//   a, b           - operands, captured on accepted start
//   abort          - (SERIAL_ADDSUB_ABORT_EN only) drop the run, no done
//   busy           - high while bits are being processed
//   done           - one-cycle pulse when result/cout/ovf are final
//   result         - sum/difference, held until the next completed run
//   cout           - final carry (subtract: 1 = no borrow)
//   ovf            - two's-complement overflow
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   opa, opb, res_sh;
  logic               carry, c_msb;
  logic [CNT_W-1:0]   cnt;
  logic               fa_sum, fa_co;

  fa_cell u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      opa    <= '0;
      opb    <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      c_msb  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Subtract as a + ~b + 1: invert B and seed the carry with 1.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef SERIAL_ADDSUB_ABORT_EN
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else
`endif
          begin
            opa    <= opa >> 1;
            opb    <= opb >> 1;
            res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
            carry  <= fa_co;
            cnt    <= cnt + 1'b1;
            // Carry out of bit WIDTH-2 is the carry into the MSB.
            if (cnt == CNT_W'(WIDTH - 2)) c_msb <= fa_co;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              result <= {fa_sum, res_sh[WIDTH-1:1]};
              cout   <= fa_co;
              ovf    <= c_msb ^ fa_co;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
